// File: rtl/data_sym_demapper.sv
// Hard-decision OFDM data-symbol demapper (BPSK/QPSK/16-QAM/64-QAM, 802.11 Gray)
// packing the variable bits-per-symbol into OUT_W-bit words with end-of-frame flush.
module data_sym_demapper #(
  parameter int IQ_W  = 16,
  parameter int OUT_W = 8,
  parameter int A16   = 4096,
  parameter int A64   = 2048
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [2*IQ_W-1:0] DAT_I,
  input  logic              WE_I,
  input  logic              STB_I,
  input  logic              CYC_I,
  input  logic [1:0]        MOD_I,
  output logic              ACK_O,
  output logic [OUT_W-1:0]  DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I
);

  // Handshake: a symbol moves on a cycle where ACK_O=1; a word moves on a
  // cycle where STB_O=1 and ACK_I=1, otherwise every pipeline register holds.

  localparam int ACC_W = OUT_W + 5;
  localparam logic [IQ_W:0] T16   = (IQ_W+1)'(2 * A16);
  localparam logic [IQ_W:0] T64_2 = (IQ_W+1)'(2 * A64);
  localparam logic [IQ_W:0] T64_4 = (IQ_W+1)'(4 * A64);
  localparam logic [IQ_W:0] T64_6 = (IQ_W+1)'(6 * A64);

  function automatic logic [IQ_W-1:0] mag(input logic [IQ_W-1:0] x);
    if (!x[IQ_W-1])
      mag = x;
    else if (x == {1'b1, {(IQ_W-1){1'b0}}})
      mag = {1'b0, {(IQ_W-1){1'b1}}};
    else
      mag = -x;
  endfunction

  logic             cyc_pp_q, cyc_pp_d;
  logic             first_pend_q, first_pend_d;
  logic [1:0]       mode_q, mode_d;
  logic             s1_vld_q, s1_vld_d;
  logic [5:0]       s1_bits_q, s1_bits_d;
  logic [2:0]       s1_nb_q, s1_nb_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] dat_q, dat_d;
  logic             stb_q, stb_d;
  logic             cyc_o_q, cyc_o_d;
  logic             flush_pend_q, flush_pend_d;

  logic             out_halt, ena, accept, need_mode;
  logic [1:0]       mode_eff;
  logic [IQ_W-1:0]  re_w, im_w;
  logic [IQ_W:0]    ar, ai;
  logic             s_r, s_i, m16_r, m16_i, m64_r, m64_i, n64_r, n64_i;
  logic [5:0]       bits;
  logic [2:0]       nb;
  logic [ACC_W-1:0] merged;
  logic [4:0]       sum;

  assign out_halt = stb_q & ~ACK_I;
  assign ena      = CYC_I & STB_I & WE_I;
  assign ACK_O    = RST_I & ena & ~out_halt & ~flush_pend_q;
  assign accept   = ACK_O;

  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = cyc_o_q;

  // The frame's mode is taken from the first accepted symbol after CYC_I rises.
  assign need_mode = (CYC_I & ~cyc_pp_q) | first_pend_q;
  assign mode_eff  = need_mode ? MOD_I : mode_q;

  assign re_w = DAT_I[IQ_W-1:0];
  assign im_w = DAT_I[2*IQ_W-1:IQ_W];
  assign ar   = {1'b0, mag(re_w)};
  assign ai   = {1'b0, mag(im_w)};

  assign s_r   = ~re_w[IQ_W-1];
  assign s_i   = ~im_w[IQ_W-1];
  assign m16_r = ar < T16;
  assign m16_i = ai < T16;
  assign m64_r = ar < T64_4;
  assign m64_i = ai < T64_4;
  assign n64_r = (ar > T64_2) && (ar < T64_6);
  assign n64_i = (ai > T64_2) && (ai < T64_6);

  always_comb begin
    bits = '0;
    nb   = 3'd1;
    case (mode_eff)
      2'd0: begin bits = {5'b0, s_r};                              nb = 3'd1; end
      2'd1: begin bits = {4'b0, s_i, s_r};                         nb = 3'd2; end
      2'd2: begin bits = {2'b0, m16_i, s_i, m16_r, s_r};           nb = 3'd4; end
      default: begin bits = {n64_i, m64_i, s_i, n64_r, m64_r, s_r}; nb = 3'd6; end
    endcase
  end

  always_comb begin
    cyc_pp_d     = CYC_I;
    first_pend_d = need_mode & ~accept;
    mode_d       = (accept & need_mode) ? MOD_I : mode_q;
    s1_vld_d     = s1_vld_q;
    s1_bits_d    = s1_bits_q;
    s1_nb_d      = s1_nb_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dat_d        = dat_q;
    stb_d        = stb_q;
    flush_pend_d = flush_pend_q;
    cyc_o_d      = cyc_o_q;
    merged       = acc_q | (ACC_W'(s1_bits_q) << cnt_q);
    sum          = cnt_q + 5'(s1_nb_q);

    if (!out_halt) begin
      s1_vld_d  = accept;
      s1_bits_d = bits;
      s1_nb_d   = nb;
      if (s1_vld_q) begin
        if (sum >= 5'(OUT_W)) begin
          dat_d = merged[OUT_W-1:0];
          stb_d = 1'b1;
          acc_d = merged >> OUT_W;
          cnt_d = sum - 5'(OUT_W);
        end else begin
          stb_d = 1'b0;
          acc_d = merged;
          cnt_d = sum;
        end
      end else if (flush_pend_q) begin
        // Bits above cnt are always zero, so the residual is already padded.
        dat_d        = acc_q[OUT_W-1:0];
        stb_d        = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end else begin
        stb_d = 1'b0;
      end
    end

    if (!flush_pend_q && !CYC_I && !s1_vld_q && (cnt_q != '0))
      flush_pend_d = 1'b1;

    // A residual still waiting to be flushed keeps the downstream cycle open.
    if (CYC_I && s1_vld_q)
      cyc_o_d = 1'b1;
    else if (!CYC_I && !stb_q && !s1_vld_q && !flush_pend_q && (cnt_q == '0))
      cyc_o_d = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cyc_pp_q     <= 1'b0;
      first_pend_q <= 1'b0;
      mode_q       <= 2'd0;
      s1_vld_q     <= 1'b0;
      s1_bits_q    <= '0;
      s1_nb_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      dat_q        <= '0;
      stb_q        <= 1'b0;
      cyc_o_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      cyc_pp_q     <= cyc_pp_d;
      first_pend_q <= first_pend_d;
      mode_q       <= mode_d;
      s1_vld_q     <= s1_vld_d;
      s1_bits_q    <= s1_bits_d;
      s1_nb_q      <= s1_nb_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dat_q        <= dat_d;
      stb_q        <= stb_d;
      cyc_o_q      <= cyc_o_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_data_sym_demapper.sv
// Bench for data_sym_demapper: bit-serial reference packer feeding an expected-word queue,
// scenario tasks for latency, thresholds, backpressure, mode latch and reset.
module tb_data_sym_demapper;
  localparam int IQ_W  = 16;
  localparam int OUT_W = 8;
  localparam int A16   = 4096;
  localparam int A64   = 2048;

  logic              CLK_I = 1'b0;
  logic              RST_I = 1'b0;
  logic [2*IQ_W-1:0] DAT_I = '0;
  logic              WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
  logic [1:0]        MOD_I = 2'd0;
  logic              ACK_O;
  logic [OUT_W-1:0]  DAT_O;
  logic              CYC_O, STB_O, WE_O;
  logic              ACK_I = 1'b1;

  data_sym_demapper #(.IQ_W(IQ_W), .OUT_W(OUT_W), .A16(A16), .A64(A64)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .MOD_I(MOD_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_bad = 0;
  int n_to  = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] m_acc = '0;
  int               m_cnt = 0;
  int               m_mode = 0;
  bit               m_first = 1'b1;

  function automatic int m_nb(int mode);
    return (mode == 0) ? 1 : (mode == 1) ? 2 : (mode == 2) ? 4 : 6;
  endfunction

  function automatic logic [5:0] m_bits(int re, int im, int mode);
    int ar, ai;
    logic [5:0] b;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    b  = '0;
    case (mode)
      0: b[0] = (re >= 0);
      1: begin b[0] = (re >= 0); b[1] = (im >= 0); end
      2: begin
        b[0] = (re >= 0); b[1] = (ar < 2*A16);
        b[2] = (im >= 0); b[3] = (ai < 2*A16);
      end
      default: begin
        b[0] = (re >= 0); b[1] = (ar < 4*A64); b[2] = (ar > 2*A64) && (ar < 6*A64);
        b[3] = (im >= 0); b[4] = (ai < 4*A64); b[5] = (ai > 2*A64) && (ai < 6*A64);
      end
    endcase
    return b;
  endfunction

  task automatic m_push(int re, int im);
    logic [5:0] b;
    b = m_bits(re, im, m_mode);
    for (int i = 0; i < m_nb(m_mode); i++) begin
      m_acc[m_cnt] = b[i];
      m_cnt++;
      if (m_cnt == OUT_W) begin
        exp_q.push_back(m_acc);
        m_acc = '0;
        m_cnt = 0;
      end
    end
  endtask

  // Scoreboard: every word transfer is checked against the oldest expected word.
  always @(negedge CLK_I) begin
    if (RST_I && STB_O && ACK_I) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL word_unexpected: got %h, none expected", DAT_O);
      end else begin
        logic [OUT_W-1:0] e;
        e = exp_q.pop_front();
        if (DAT_O !== e) begin
          n_bad++;
          $display("FAIL word_data: got %h, expected %h", DAT_O, e);
        end
      end
    end
  end

  task automatic send_sym(int re, int im, int mod);
    logic [IQ_W-1:0] r16, i16;
    bit got;
    r16   = IQ_W'(re);
    i16   = IQ_W'(im);
    DAT_I = {i16, r16};
    MOD_I = 2'(mod);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        got = 1'b1;
        if (m_first) begin m_mode = mod; m_first = 1'b0; end
        m_push(re, im);
      end
      @(posedge CLK_I); #1;
    end
    STB_I = 1'b0; WE_I = 1'b0;
    if (!got) n_to++;
  endtask

  task automatic end_frame();
    bit done;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    if (m_cnt > 0) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end
    m_first = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge CLK_I);
      if (exp_q.size() == 0 && !CYC_O && !STB_O) done = 1'b1;
    end
    if (!done) n_to++;
    @(posedge CLK_I); #1;
  endtask

  task automatic test_reset();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    n_cmp++; if (ACK_O !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b, expected 0", ACK_O); end
    n_cmp++; if (STB_O !== 1'b0 || WE_O !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b/%b, expected 0/0", STB_O, WE_O); end
    n_cmp++; if (CYC_O !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b, expected 0", CYC_O); end
    n_cmp++; if (DAT_O !== '0) begin n_bad++; $display("FAIL reset_dat: got %h, expected 0", DAT_O); end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I); #1;
  endtask

  task automatic test_qpsk();
    int to0;
    to0 = n_to;
    // bit pair of each symbol is {~Im.msb, ~Re.msb}
    send_sym( 1000,  1000, 1);
    send_sym( 1000, -1000, 1);
    send_sym(-1000,  1000, 1);
    send_sym(-1000, -1000, 1);
    @(negedge CLK_I);
    n_cmp++; if (STB_O !== 1'b0) begin n_bad++; $display("FAIL qpsk_early: STB_O %b at accept+1, expected 0", STB_O); end
    @(negedge CLK_I);
    n_cmp++; if (STB_O !== 1'b1) begin n_bad++; $display("FAIL qpsk_latency: STB_O %b at accept+2, expected 1", STB_O); end
    n_cmp++; if (DAT_O !== 8'h27) begin n_bad++; $display("FAIL qpsk_word: got %h, expected 27", DAT_O); end
    n_cmp++; if (WE_O !== STB_O) begin n_bad++; $display("FAIL qpsk_we: WE_O %b, expected %b", WE_O, STB_O); end
    @(posedge CLK_I); #1;
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL qpsk_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_qam16();
    int to0;
    to0 = n_to;
    send_sym(1000, -12000, 2);
    send_sym(1000, -12000, 2);
    @(negedge CLK_I);
    @(negedge CLK_I);
    n_cmp++; if (STB_O !== 1'b1 || DAT_O !== 8'h33) begin n_bad++; $display("FAIL qam16_word: got stb %b dat %h, expected 1 33", STB_O, DAT_O); end
    @(posedge CLK_I); #1;
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL qam16_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_qam64_flush();
    int to0;
    to0 = n_to;
    // 12000 sits between 4*A64 and 6*A64: s=1, m=0, n=1 -> words 6D, DB, flush 02
    repeat (3) send_sym(12000, 12000, 3);
    n_cmp++; if (m_cnt != 2) begin n_bad++; $display("FAIL qam64_residual: model holds %0d bits, expected 2", m_cnt); end
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL qam64_flush_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_thresholds();
    int to0;
    to0 = n_to;
    send_sym(0, 5, 0); send_sym(-1, 5, 0); send_sym(32767, 0, 0); send_sym(-32768, 0, 0);
    end_frame();
    send_sym(8192, 8191, 2); send_sym(-8192, -8191, 2); send_sym(-32768, 0, 2);
    end_frame();
    send_sym(4096, 4097, 3); send_sym(12288, 12287, 3); send_sym(8192, 8191, 3);
    send_sym(-32768, -4096, 3); send_sym(-12288, -12289, 3);
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL thresh_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_backpressure();
    int to0;
    to0 = n_to;
    ACK_I = 1'b0;
    fork
      begin
        send_sym( 1000,  1000, 1); send_sym( 1000, -1000, 1);
        send_sym(-1000,  1000, 1); send_sym(-1000, -1000, 1);
        repeat (4) send_sym(1000, 1000, 1);
        end_frame();
      end
      begin
        logic [OUT_W-1:0] held;
        bit seen, bad_stb, bad_dat, bad_ack;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge CLK_I);
          if (STB_O) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_word: no word within 50 cycles, expected one"); end
        held = DAT_O;
        bad_stb = 1'b0; bad_dat = 1'b0; bad_ack = 1'b0;
        repeat (5) begin
          @(negedge CLK_I);
          if (STB_O !== 1'b1) bad_stb = 1'b1;
          if (DAT_O !== held) bad_dat = 1'b1;
          if (ACK_O !== 1'b0) bad_ack = 1'b1;
        end
        n_cmp++; if (bad_stb) begin n_bad++; $display("FAIL bp_stb: STB_O dropped while halted, expected 1"); end
        n_cmp++; if (bad_dat) begin n_bad++; $display("FAIL bp_dat: DAT_O moved from %h while halted", held); end
        n_cmp++; if (bad_ack) begin n_bad++; $display("FAIL bp_ack: ACK_O rose while halted, expected 0"); end
        @(posedge CLK_I); #1;
        ACK_I = 1'b1;
      end
    join
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL bp_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_mode_change();
    int to0;
    to0 = n_to;
    send_sym(1000, 1000, 1);
    send_sym(-1000, 12000, 3); send_sym(12000, -1000, 3); send_sym(5000, 5000, 3);
    end_frame();
    send_sym(12000, 12000, 3); send_sym(-5000, 1000, 3);
    send_sym(3000, -9000, 3); send_sym(-13000, 200, 3);
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL mode_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  function automatic int rand_axis();
    int thr[10];
    thr = '{0, -1, 8191, 8192, 4096, 4097, 12287, 12288, -32768, 32767};
    if ($urandom_range(0, 1) == 0) return thr[$urandom_range(0, 9)];
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_random();
    int to0;
    bit done;
    to0  = n_to;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          int md, ns;
          md = int'($urandom_range(0, 3));
          ns = int'($urandom_range(1, 12));
          for (int s = 0; s < ns; s++) send_sym(rand_axis(), rand_axis(), md);
          end_frame();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK_I); #1;
          ACK_I = ($urandom_range(0, 3) != 0);
        end
        ACK_I = 1'b1;
      end
    join
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL random_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  task automatic test_reset_mid_frame();
    int to0;
    bit bad_out;
    to0 = n_to;
    repeat (5) send_sym(1000, 0, 0);
    CYC_I = 1'b1;
    repeat (3) @(posedge CLK_I);
    #3;
    STB_I = 1'b1; WE_I = 1'b1;
    RST_I = 1'b0;
    #1;
    n_cmp++; if (ACK_O !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got %b, expected 0", ACK_O); end
    n_cmp++; if (STB_O !== 1'b0 || CYC_O !== 1'b0 || DAT_O !== '0) begin n_bad++; $display("FAIL rst_mid_out: stb %b cyc %b dat %h, expected 0 0 00", STB_O, CYC_O, DAT_O); end
    exp_q.delete();
    m_acc = '0; m_cnt = 0; m_first = 1'b1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    bad_out = 1'b0;
    repeat (10) begin
      @(negedge CLK_I);
      if (STB_O !== 1'b0 || ACK_O !== 1'b0) bad_out = 1'b1;
    end
    n_cmp++; if (bad_out) begin n_bad++; $display("FAIL rst_mid_residual: output activity after reset, expected none"); end
    @(posedge CLK_I); #1;
    send_sym(1000, 1000, 1); send_sym(-1000, 1000, 1);
    send_sym(1000, -1000, 1); send_sym(1000, 1000, 1);
    end_frame();
    n_cmp++; if (n_to != to0) begin n_bad++; $display("FAIL rst_mid_timeout: %0d timeouts, expected 0", n_to - to0); end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_qam16();
    test_qam64_flush();
    test_thresholds();
    test_backpressure();
    test_mode_change();
    test_random();
    test_reset_mid_frame();
    repeat (5) @(posedge CLK_I);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL final_queue: %0d words outstanding, expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
